ip1_testx_config_clk_gen: RTL

Timing source for all ip1_testN state machines. Produces the fast and slow config clocks as clk-domain registered levels, plus the free-running phase counters clk_counter_fc and clk_counter_sc. Test state machines compare these counters against test_delay or half-period values to place shift strobes and config_in transitions. Sits directly upstream of every ip1_testN block; one instance per IP.

---
 rtl/ip1_testx_pkg.sv | 13 +
 rtl/ip1_clk_div_ch.sv | 73 +++++++
 rtl/ip1_testx_config_clk_gen.sv | 56 +++++
 3 files changed

// File: rtl/ip1_testx_pkg.sv
// Shared widths, default periods and the half-period helper for the config clock generator.
package ip1_testx_pkg;
  localparam int FC_W              = 7;
  localparam int SC_W              = 27;
  localparam int MIN_PERIOD        = 2;
  localparam int FC_PERIOD_DEFAULT = 10;
  localparam int SC_PERIOD_DEFAULT = 1000;

  // High time of a channel: floor(P/2), so odd periods spend the extra cycle low.
  function automatic logic [31:0] half_period(input logic [31:0] p);
    return {1'b0, p[31:1]};
  endfunction
endpackage

// File: rtl/ip1_clk_div_ch.sv
// One config clock channel: shadow period with clamp, phase counter, clock level, wrap, strobes.
// Latency: outputs registered one clk after inputs; strobes lead the registered clock edge by one clk.
// Backpressure: none; enable=0 idles the channel. Strobes exist only with IP1_CLKGEN_EDGE_STROBE_EN.
module ip1_clk_div_ch
  import ip1_testx_pkg::*;
#(
  parameter int W       = 7,
  parameter int DEFAULT = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         restart,
  input  logic [W-1:0] period_req,
  output logic [W-1:0] counter,
  output logic         cfg_clk,
  output logic         wrap,
  output logic         period_err,
  output logic         rise,
  output logic         fall
);
  logic [W-1:0] period_q, period_d, req_clamped, cnt_d, half_d;
  logic         running, bad_req, load, clk_d, wrap_d, err_d;

  assign bad_req     = period_req < W'(MIN_PERIOD);
  assign req_clamped = bad_req ? W'(MIN_PERIOD) : period_req;

  always_comb begin
    load     = 1'b0;
    err_d    = period_err;
    period_d = period_q;
    cnt_d    = '0;
    if (restart) begin
      load  = 1'b1;
      err_d = bad_req;
    end else if (enable && running && wrap) begin
      load  = 1'b1;
      err_d = period_err | bad_req;
    end
    if (load) period_d = req_clamped;
    // First enabled cycle after idle starts from phase 0, exactly like a restart.
    if (enable && running && !restart && !wrap) cnt_d = counter + W'(1);
    half_d = W'(half_period(32'(period_d)));
    clk_d  = enable && (cnt_d < half_d);
    wrap_d = enable && (cnt_d == period_d - W'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      period_q   <= W'(DEFAULT);
      counter    <= '0;
      cfg_clk    <= 1'b0;
      wrap       <= 1'b0;
      period_err <= 1'b0;
      running    <= 1'b0;
    end else begin
      period_q   <= period_d;
      counter    <= cnt_d;
      cfg_clk    <= clk_d;
      wrap       <= wrap_d;
      period_err <= err_d;
      running    <= enable;
    end
  end

`ifdef IP1_CLKGEN_EDGE_STROBE_EN
  assign rise = enable && !reset && clk_d && !cfg_clk;
  assign fall = enable && !reset && !clk_d && cfg_clk;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif
endmodule

// File: rtl/ip1_testx_config_clk_gen.sv
// Fast/slow config clock generator feeding the ip1_testN state machines; optional IP1_CLKGEN_EDGE_STROBE_EN.
// Latency: one clk from enable/restart to counters and clocks. Backpressure: none, free-running.
// Both channels are independent; period_err is the OR of the per-channel sticky flags.
module ip1_testx_config_clk_gen
  import ip1_testx_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            restart,
  input  logic [FC_W-1:0] fast_configclk_period,
  input  logic [SC_W-1:0] slow_configclk_period,
  output logic [FC_W-1:0] clk_counter_fc,
  output logic [SC_W-1:0] clk_counter_sc,
  output logic            sm_testx_i_fast_config_clk,
  output logic            sm_testx_i_slow_config_clk,
  output logic            fc_wrap,
  output logic            sc_wrap,
  output logic            period_err,
  output logic            fc_rise,
  output logic            fc_fall,
  output logic            sc_rise,
  output logic            sc_fall
);
  logic fc_err, sc_err;

  ip1_clk_div_ch #(.W(FC_W), .DEFAULT(FC_PERIOD_DEFAULT)) u_fast (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .restart    (restart),
    .period_req (fast_configclk_period),
    .counter    (clk_counter_fc),
    .cfg_clk    (sm_testx_i_fast_config_clk),
    .wrap       (fc_wrap),
    .period_err (fc_err),
    .rise       (fc_rise),
    .fall       (fc_fall)
  );

  ip1_clk_div_ch #(.W(SC_W), .DEFAULT(SC_PERIOD_DEFAULT)) u_slow (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .restart    (restart),
    .period_req (slow_configclk_period),
    .counter    (clk_counter_sc),
    .cfg_clk    (sm_testx_i_slow_config_clk),
    .wrap       (sc_wrap),
    .period_err (sc_err),
    .rise       (sc_rise),
    .fall       (sc_fall)
  );

  assign period_err = fc_err | sc_err;
endmodule
